// File: rtl/load_id_tracker_pkg.sv
// Shared types and sizing for the outstanding-load tracker.
// The transaction-ID width is derived from the core configuration record.
package load_id_tracker_pkg;

   typedef struct packed {
      int unsigned NrLoadBufEntries;
      int unsigned NrScoreboardEntries;
   } cva6_cfg_t;

   localparam cva6_cfg_t CVA6Cfg = '{
      NrLoadBufEntries:    32'd8,
      NrScoreboardEntries: 32'd8
   };

   localparam int unsigned IdWidth   = $clog2(CVA6Cfg.NrLoadBufEntries);
   localparam int unsigned SbIdWidth = $clog2(CVA6Cfg.NrScoreboardEntries);
   localparam int unsigned XLEN      = 64;

   typedef enum logic [1:0] {
      BYTE  = 2'd0,
      HALF  = 2'd1,
      WORD  = 2'd2,
      DWORD = 2'd3
   } load_size_e;

   typedef struct packed {
      logic                 valid;
      logic                 killed;
      logic [SbIdWidth-1:0] sb_id;
      logic [2:0]           offset;
      load_size_e           size;
      logic                 is_signed;
   } load_entry_t;

endpackage

// File: rtl/load_data_align.sv
// Combinational formatting of a raw 64-bit dcache word into a load result:
// shift down by the byte offset, keep the access size, then sign/zero extend.
module load_data_align
   import load_id_tracker_pkg::*;
(
   input  logic [XLEN-1:0] rsp_data,
   input  logic [2:0]      offset,
   input  logic [1:0]      size,
   input  logic            is_signed,
   output logic [XLEN-1:0] data
);

   logic [5:0]      shamt;
   logic [XLEN-1:0] shifted;

   // Doubleword accesses are always naturally aligned, so the offset is ignored.
   always_comb begin
      shamt = 6'd0;
      if (load_size_e'(size) == DWORD) begin
         shamt = 6'd0;
      end else begin
         shamt = {offset, 3'b000};
      end
      shifted = rsp_data >> shamt;
   end

   // Truncate to the access size and extend.
   always_comb begin
      data = '0;
      case (load_size_e'(size))
         BYTE:    data = {{56{is_signed & shifted[7]}},  shifted[7:0]};
         HALF:    data = {{48{is_signed & shifted[15]}}, shifted[15:0]};
         WORD:    data = {{32{is_signed & shifted[31]}}, shifted[31:0]};
         DWORD:   data = shifted;
         default: data = shifted;
      endcase
   end

endmodule

// File: rtl/load_id_tracker_chk.sv
// Simulation-only checks for the load tracker: a dcache response must
// always target an entry that is currently outstanding.
module load_id_tracker_chk #(
   parameter int unsigned NrLoadBufEntries = 8,
   parameter int unsigned IdWidth          = $clog2(NrLoadBufEntries)
) (
   input logic                        clk_i,
   input logic                        rst_i,
   input logic                        rsp_valid_i,
   input logic [IdWidth-1:0]          rsp_id_i,
   input logic [NrLoadBufEntries-1:0] valid_vec
);

   // Responses to idle IDs are dropped by the tracker; flag them here.
   always @(posedge clk_i) begin
      if (!rst_i && rsp_valid_i) begin
         assert (valid_vec[rsp_id_i])
         else $warning("load_id_tracker: response to idle id %0d ignored", rsp_id_i);
      end
   end

endmodule

// File: rtl/load_id_tracker.sv
// Outstanding-load tracker: hands out dcache transaction IDs, remembers how to
// format each returning word, and retires responses in any order.
module load_id_tracker
   import load_id_tracker_pkg::*;
#(
   parameter int unsigned NrLoadBufEntries = CVA6Cfg.NrLoadBufEntries,
   parameter int unsigned IdWidth          = $clog2(NrLoadBufEntries)
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 flush_i,
   input  logic                 alloc_valid_i,
   output logic                 alloc_ready_o,
   input  logic [SbIdWidth-1:0] alloc_sb_id_i,
   input  logic [2:0]           alloc_offset_i,
   input  logic [1:0]           alloc_size_i,
   input  logic                 alloc_signed_i,
   output logic [IdWidth-1:0]   alloc_id_o,
   input  logic                 kill_valid_i,
   input  logic [IdWidth-1:0]   kill_id_i,
   input  logic                 rsp_valid_i,
   input  logic [IdWidth-1:0]   rsp_id_i,
   input  logic [XLEN-1:0]      rsp_data_i,
   output logic                 result_valid_o,
   output logic [SbIdWidth-1:0] result_sb_id_o,
   output logic [XLEN-1:0]      result_data_o,
   output logic                 empty_o,
   output logic                 full_o
);

   load_entry_t                 entries_r [NrLoadBufEntries];
   logic [NrLoadBufEntries-1:0] valid_vec_s;
   logic [IdWidth-1:0]          free_id_s;
   logic                        alloc_fire_s;
   load_entry_t                 rsp_entry_s;
   logic                        rsp_hit_s;
   logic                        rsp_killed_s;
   logic                        produce_s;
   logic [XLEN-1:0]             aligned_data_s;

   logic                        result_valid_r;
   logic [SbIdWidth-1:0]        result_sb_id_r;
   logic [XLEN-1:0]             result_data_r;

   // Occupancy view and lowest-index free slot, both from registered state only.
   always_comb begin
      valid_vec_s = '0;
      free_id_s   = '0;
      for (int i = int'(NrLoadBufEntries) - 1; i >= 0; i--) begin
         valid_vec_s[i] = entries_r[i].valid;
         free_id_s      = entries_r[i].valid ? free_id_s : IdWidth'(i);
      end
   end

   assign full_o        = &valid_vec_s;
   assign empty_o       = ~|valid_vec_s;
   assign alloc_ready_o = !full_o && !flush_i;
   assign alloc_id_o    = free_id_s;
   assign alloc_fire_s  = alloc_valid_i && alloc_ready_o;

   // A response yields data only if its entry survived kills and flushes,
   // including ones arriving in the same cycle.
   always_comb begin
      rsp_entry_s  = entries_r[rsp_id_i];
      rsp_hit_s    = rsp_valid_i && rsp_entry_s.valid;
      rsp_killed_s = rsp_entry_s.killed || flush_i ||
                     (kill_valid_i && (kill_id_i == rsp_id_i));
      produce_s    = rsp_hit_s && !rsp_killed_s;
   end

   // Per-entry bookkeeping: retire, allocate, or mark killed.
   always_ff @(posedge clk_i) begin
      for (int i = 0; i < int'(NrLoadBufEntries); i++) begin
         if (rst_i) begin
            entries_r[i] <= '0;
         end else if (rsp_hit_s && (rsp_id_i == IdWidth'(i))) begin
            entries_r[i] <= '0;
         end else if (alloc_fire_s && (free_id_s == IdWidth'(i))) begin
            entries_r[i] <= '{
               valid:     1'b1,
               killed:    1'b0,
               sb_id:     alloc_sb_id_i,
               offset:    alloc_offset_i,
               size:      load_size_e'(alloc_size_i),
               is_signed: alloc_signed_i
            };
         end else if (entries_r[i].valid &&
                      (flush_i || (kill_valid_i && (kill_id_i == IdWidth'(i))))) begin
            entries_r[i].killed <= 1'b1;
         end else begin
            entries_r[i] <= entries_r[i];
         end
      end
   end

   load_data_align i_align (
      .rsp_data  (rsp_data_i),
      .offset    (rsp_entry_s.offset),
      .size      (rsp_entry_s.size),
      .is_signed (rsp_entry_s.is_signed),
      .data      (aligned_data_s)
   );

   // Result register: one cycle after the response, no backpressure.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         result_valid_r <= 1'b0;
         result_sb_id_r <= '0;
         result_data_r  <= '0;
      end else begin
         result_valid_r <= produce_s;
         if (produce_s) begin
            result_sb_id_r <= rsp_entry_s.sb_id;
            result_data_r  <= aligned_data_s;
         end else begin
            result_sb_id_r <= result_sb_id_r;
            result_data_r  <= result_data_r;
         end
      end
   end

   assign result_valid_o = result_valid_r;
   assign result_sb_id_o = result_sb_id_r;
   assign result_data_o  = result_data_r;

`ifndef SYNTHESIS
   load_id_tracker_chk #(
      .NrLoadBufEntries (NrLoadBufEntries),
      .IdWidth          (IdWidth)
   ) i_chk (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .rsp_valid_i (rsp_valid_i),
      .rsp_id_i    (rsp_id_i),
      .valid_vec   (valid_vec_s)
   );
`endif

endmodule
